// File: rtl/tpu_resource_arbiter_if.sv
// Purpose: bundles requester, weight-ROM and MultAdder signals shared through tpu_resource_arbiter.
// Latency: none, wires only. Timing is set by the arbiter.
// Backpressure: none here. Requesters are throttled by the registered one-hot grant.
// Signal groups:
//   req/grant/timeout_err/busy    ownership and status
//   rd_en/rd_addr -> rom_en/rom_addr          ROM request path (owner only)
//   rom_data -> rd_data, rd_valid             tagged ROM return path
//   opr1/opr2 -> ma_opr1/ma_opr2, ma_result -> ma_data   MultAdder path
// Modports: master = requester/memory side, slave = arbiter.
interface tpu_resource_arbiter_if #(
  parameter int NREQ   = 3,
  parameter int ADDR_W = 11,
  parameter int BIT    = 8,
  parameter int LANES  = 128
);
  localparam int DW = LANES * BIT;
  localparam int MW = 2 * BIT - 1;

  logic [NREQ-1:0]        req;
  logic [NREQ-1:0]        grant;
  logic [NREQ-1:0]        rd_en;
  logic [NREQ*ADDR_W-1:0] rd_addr;
  logic                   rom_en;
  logic [ADDR_W-1:0]      rom_addr;
  logic [DW-1:0]          rom_data;
  logic [DW-1:0]          rd_data;
  logic [NREQ-1:0]        rd_valid;
  logic [NREQ*DW-1:0]     opr1;
  logic [NREQ*DW-1:0]     opr2;
  logic [DW-1:0]          ma_opr1;
  logic [DW-1:0]          ma_opr2;
  logic [MW-1:0]          ma_result;
  logic [MW-1:0]          ma_data;
  logic [NREQ-1:0]        timeout_err;
  logic                   busy;

  modport master (
    output req, rd_en, rd_addr, opr1, opr2, rom_data, ma_result,
    input  grant, rom_en, rom_addr, rd_data, rd_valid, ma_opr1, ma_opr2,
           ma_data, timeout_err, busy
  );

  modport slave (
    input  req, rd_en, rd_addr, opr1, opr2, rom_data, ma_result,
    output grant, rom_en, rom_addr, rd_data, rd_valid, ma_opr1, ma_opr2,
           ma_data, timeout_err, busy
  );
endinterface

// File: rtl/tpu_resource_arbiter.sv
// Purpose: round-robin owner of the weight ROM port and MultAdder among NREQ layer engines.
// Latency: grant 1 cycle after req seen in IDLE. ROM returns tagged ROM_LAT cycles after rom_en. MultAdder is pass-through.
// Backpressure: a requester waits for its grant. Release or revoke is followed by ROM_LAT drain cycles before the next grant.
// Ports:
//   clk     system clock
//   iRst    synchronous active-high reset
//   arb_if  slave modport: req/grant, rd_en/rd_addr -> rom_en/rom_addr,
//           rom_data -> rd_data/rd_valid, opr1/opr2 -> ma_opr1/ma_opr2,
//           ma_result -> ma_data, timeout_err, busy
module tpu_resource_arbiter #(
  parameter int NREQ    = 3,
  parameter int ADDR_W  = 11,
  parameter int BIT     = 8,
  parameter int LANES   = 128,
  parameter int ROM_LAT = 1,
  parameter int TIMEOUT = 65535
) (
  input  logic                 clk,
  input  logic                 iRst,
  tpu_resource_arbiter_if.slave arb_if
);
  localparam int DW    = LANES * BIT;
  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TEN_W = $clog2(TIMEOUT + 1);
  localparam int DR_W  = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;

  localparam logic [TEN_W-1:0] TEN_LAST = TEN_W'(TIMEOUT - 1);
  localparam logic [DR_W-1:0]  DR_LAST  = DR_W'(ROM_LAT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NREQ - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // One slot of the read-return tag pipeline.
  typedef struct packed {
    logic             vld;
    logic [IDX_W-1:0] idx;
  } tag_t;

  state_t            state_q,  state_d;
  logic [NREQ-1:0]   grant_q,  grant_d;
  logic [IDX_W-1:0]  owner_q,  owner_d;
  logic [IDX_W-1:0]  last_q,   last_d;
  logic [TEN_W-1:0]  tenure_q, tenure_d;
  logic [DR_W-1:0]   drain_q,  drain_d;
  logic [NREQ-1:0]   terr_q,   terr_d;
  logic [NREQ-1:0]   inelig_q, inelig_d;
  tag_t              tag_q [ROM_LAT];

  logic [NREQ-1:0]   elig;
  logic              pick_vld;
  logic [IDX_W-1:0]  pick_idx;
  logic [IDX_W-1:0]  cand;

  logic              rom_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [DW-1:0]     ma_opr1;
  logic [DW-1:0]     ma_opr2;
  logic [NREQ-1:0]   rd_valid;

  // A requester revoked by the watchdog stays out of arbitration until
  // it has dropped req at least once.
  assign elig = arb_if.req & ~inelig_q;

  // Round-robin pick. Scan from farthest to nearest after last_q, so the
  // final hit (the nearest eligible index) wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = IDX_W'((int'(last_q) + k) % NREQ);
      if (elig[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    owner_d  = owner_q;
    last_d   = last_q;
    tenure_d = tenure_q;
    drain_d  = drain_q;
    terr_d   = terr_q;
    // Any cycle with req low restores eligibility.
    inelig_d = inelig_q & arb_if.req;

    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d  = OWN;
          owner_d  = pick_idx;
          grant_d  = NREQ'(1) << pick_idx;
          tenure_d = '0;
        end
      end

      OWN: begin
        if (!arb_if.req[owner_q]) begin
          state_d = DRAIN;
          grant_d = '0;
          last_d  = owner_q;
          drain_d = '0;
        end else if (tenure_q == TEN_LAST) begin
          // Watchdog revoke. The owner keeps req high, so it is fenced off
          // until it pulses req low.
          state_d           = DRAIN;
          grant_d           = '0;
          last_d            = owner_q;
          drain_d           = '0;
          terr_d[owner_q]   = 1'b1;
          inelig_d[owner_q] = 1'b1;
        end else begin
          tenure_d = tenure_q + 1'b1;
        end
      end

      DRAIN: begin
        // ROM_LAT cycles let the last reads return before ownership moves.
        if (drain_q == DR_LAST) begin
          state_d = IDLE;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (iRst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      owner_q  <= '0;
      last_q   <= IDX_LAST;
      tenure_q <= '0;
      drain_q  <= '0;
      terr_q   <= '0;
      inelig_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      tenure_q <= tenure_d;
      drain_q  <= drain_d;
      terr_q   <= terr_d;
      inelig_q <= inelig_d;
    end
  end

  // Tag pipeline mirrors the ROM latency. Each issued read carries its
  // issuer's index, so data returning after a release is still routed
  // to the right engine.
  always_ff @(posedge clk) begin
    if (iRst) begin
      for (int s = 0; s < ROM_LAT; s++) begin
        tag_q[s] <= '0;
      end
    end else begin
      tag_q[0] <= '{vld: rom_en, idx: owner_q};
      for (int s = 1; s < ROM_LAT; s++) begin
        tag_q[s] <= tag_q[s-1];
      end
    end
  end

  always_comb begin
    rd_valid = '0;
    if (tag_q[ROM_LAT-1].vld) begin
      rd_valid[tag_q[ROM_LAT-1].idx] = 1'b1;
    end
  end

  // Owner mux. Drives zeros whenever no one holds the grant.
  always_comb begin
    rom_en   = 1'b0;
    rom_addr = '0;
    ma_opr1  = '0;
    ma_opr2  = '0;
    if (state_q == OWN) begin
      rom_en   = arb_if.rd_en[owner_q];
      rom_addr = arb_if.rd_addr[int'(owner_q)*ADDR_W +: ADDR_W];
      ma_opr1  = arb_if.opr1[int'(owner_q)*DW +: DW];
      ma_opr2  = arb_if.opr2[int'(owner_q)*DW +: DW];
    end
  end

  assign arb_if.grant       = grant_q;
  assign arb_if.rom_en      = rom_en;
  assign arb_if.rom_addr    = rom_addr;
  assign arb_if.ma_opr1     = ma_opr1;
  assign arb_if.ma_opr2     = ma_opr2;
  assign arb_if.rd_valid    = rd_valid;
  assign arb_if.rd_data     = arb_if.rom_data;
  assign arb_if.ma_data     = arb_if.ma_result;
  assign arb_if.timeout_err = terr_q;
  assign arb_if.busy        = (state_q != IDLE);

endmodule

// File: tb/tb_tpu_resource_arbiter.sv
// Purpose: self-checking bench for tpu_resource_arbiter with directed and random stimulus.
// Latency: cycle-accurate reference model updated at each rising edge; outputs sampled mid-cycle.
// Backpressure: n/a (bench drives requesters freely).
module tb_tpu_resource_arbiter;
  localparam int NREQ    = 3;
  localparam int ADDR_W  = 11;
  localparam int BIT     = 8;
  localparam int LANES   = 4;
  localparam int ROM_LAT = 2;
  localparam int TIMEOUT = 16;
  localparam int DW      = LANES * BIT;
  localparam int MW      = 2 * BIT - 1;

  logic clk = 1'b0;
  logic iRst;
  always #5 clk = ~clk;

  logic [NREQ-1:0]        req;
  logic [NREQ-1:0]        rd_en;
  logic [NREQ*ADDR_W-1:0] rd_addr;
  logic [NREQ*DW-1:0]     opr1;
  logic [NREQ*DW-1:0]     opr2;
  logic [DW-1:0]          rom_data;
  logic [MW-1:0]          ma_result;

  tpu_resource_arbiter_if #(.NREQ(NREQ), .ADDR_W(ADDR_W), .BIT(BIT), .LANES(LANES)) bus ();

  assign bus.req       = req;
  assign bus.rd_en     = rd_en;
  assign bus.rd_addr   = rd_addr;
  assign bus.opr1      = opr1;
  assign bus.opr2      = opr2;
  assign bus.rom_data  = rom_data;
  assign bus.ma_result = ma_result;

  tpu_resource_arbiter #(
    .NREQ(NREQ), .ADDR_W(ADDR_W), .BIT(BIT), .LANES(LANES),
    .ROM_LAT(ROM_LAT), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk    (clk),
    .iRst   (iRst),
    .arb_if (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: who owns, how long, how many drain cycles remain,
  // and a list of outstanding reads with the cycle they are due back.
  int              m_owner;
  int              m_owned;
  int              m_drain;
  int              m_last;
  int              m_cyc;
  logic [NREQ-1:0] m_terr;
  logic [NREQ-1:0] m_inelig;
  int              m_due[$];
  int              m_idx[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner  = -1;
    m_owned  = 0;
    m_drain  = 0;
    m_last   = NREQ - 1;
    m_terr   = '0;
    m_inelig = '0;
    m_due.delete();
    m_idx.delete();
  endtask

  task automatic model_edge();
    logic [NREQ-1:0] nxt_inelig;
    if (iRst) begin
      model_reset();
      m_cyc++;
      return;
    end
    if (m_owner >= 0 && rd_en[m_owner]) begin
      m_due.push_back(m_cyc + ROM_LAT);
      m_idx.push_back(m_owner);
    end
    m_cyc++;
    while (m_due.size() > 0 && m_due[0] < m_cyc) begin
      void'(m_due.pop_front());
      void'(m_idx.pop_front());
    end
    nxt_inelig = m_inelig & req;
    if (m_owner >= 0) begin
      m_owned++;
      if (!req[m_owner]) begin
        m_last  = m_owner;
        m_owner = -1;
        m_drain = ROM_LAT;
      end else if (m_owned == TIMEOUT) begin
        m_terr[m_owner]     = 1'b1;
        nxt_inelig[m_owner] = 1'b1;
        m_last  = m_owner;
        m_owner = -1;
        m_drain = ROM_LAT;
      end
    end else if (m_drain > 0) begin
      m_drain--;
    end else begin
      for (int k = 1; k <= NREQ; k++) begin
        int c;
        c = (m_last + k) % NREQ;
        if (req[c] && !m_inelig[c]) begin
          m_owner = c;
          m_owned = 0;
          break;
        end
      end
    end
    m_inelig = nxt_inelig;
  endtask

  task automatic check_all(input string tag);
    logic [NREQ-1:0]   eg;
    logic [NREQ-1:0]   ev;
    logic              ee;
    logic [ADDR_W-1:0] ea;
    logic [DW-1:0]     e1;
    logic [DW-1:0]     e2;
    eg = '0; ev = '0; ee = 1'b0; ea = '0; e1 = '0; e2 = '0;
    if (m_owner >= 0) begin
      eg[m_owner] = 1'b1;
      ee = rd_en[m_owner];
      ea = rd_addr[m_owner*ADDR_W +: ADDR_W];
      e1 = opr1[m_owner*DW +: DW];
      e2 = opr2[m_owner*DW +: DW];
    end
    for (int i = 0; i < m_due.size(); i++) begin
      if (m_due[i] == m_cyc) ev[m_idx[i]] = 1'b1;
    end
    chk({tag, ".grant"},    64'(bus.grant),       64'(eg));
    chk({tag, ".rom_en"},   64'(bus.rom_en),      64'(ee));
    chk({tag, ".rom_addr"}, 64'(bus.rom_addr),    64'(ea));
    chk({tag, ".ma_opr1"},  64'(bus.ma_opr1),     64'(e1));
    chk({tag, ".ma_opr2"},  64'(bus.ma_opr2),     64'(e2));
    chk({tag, ".rd_valid"}, 64'(bus.rd_valid),    64'(ev));
    chk({tag, ".rd_data"},  64'(bus.rd_data),     64'(rom_data));
    chk({tag, ".ma_data"},  64'(bus.ma_data),     64'(ma_result));
    chk({tag, ".terr"},     64'(bus.timeout_err), 64'(m_terr));
    chk({tag, ".busy"},     64'(bus.busy),        64'(m_owner >= 0 || m_drain > 0));
  endtask

  // Check the current cycle against the model, then advance one clock.
  task automatic step(input string tag);
    #1;
    check_all(tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic rand_data();
    for (int i = 0; i < NREQ; i++) begin
      rd_addr[i*ADDR_W +: ADDR_W] = ADDR_W'($urandom);
      opr1[i*DW +: DW]            = DW'($urandom);
      opr2[i*DW +: DW]            = DW'($urandom);
    end
    rom_data  = DW'($urandom);
    ma_result = MW'($urandom);
  endtask

  initial begin
    int              g0_cycles;
    logic [NREQ-1:0] after0;
    logic [NREQ-1:0] terr_cap;
    logic            cap_done;

    iRst = 1'b1;
    req = '0; rd_en = '0; rd_addr = '0; opr1 = '0; opr2 = '0;
    rom_data = '0; ma_result = '0;
    m_cyc = 0;
    model_reset();
    @(negedge clk);

    // Reset state
    step("rst");
    chk("rst.grant", 64'(bus.grant), 64'(0));
    chk("rst.busy", 64'(bus.busy), 64'(0));
    chk("rst.rom_en", 64'(bus.rom_en), 64'(0));
    chk("rst.rd_valid", 64'(bus.rd_valid), 64'(0));
    chk("rst.terr", 64'(bus.timeout_err), 64'(0));
    iRst = 1'b0;
    step("rst");

    // Round-robin order under all-request
    req = 3'b111;
    step("rr");
    chk("rr.first_grant", 64'(bus.grant), 64'(3'b001));
    step("rr"); step("rr");
    req[0] = 1'b0;
    repeat (ROM_LAT + 2) step("rr");
    chk("rr.second_grant", 64'(bus.grant), 64'(3'b010));
    step("rr");
    req[1] = 1'b0;
    repeat (ROM_LAT + 2) step("rr");
    chk("rr.third_grant", 64'(bus.grant), 64'(3'b100));
    step("rr");
    req[2] = 1'b0;
    repeat (ROM_LAT + 2) step("rr");
    chk("rr.all_idle", 64'(bus.grant), 64'(0));

    // Back-to-back reads by requester 1, release with the last address
    rom_data = 32'hCAFE_0001;
    req = 3'b010;
    step("rd");
    chk("rd.grant", 64'(bus.grant), 64'(3'b010));
    rd_en = 3'b010;
    rd_addr[1*ADDR_W +: ADDR_W] = 11'd5;
    #1; chk("rd.addr5", 64'(bus.rom_addr), 64'(5));
    chk("rd.en5", 64'(bus.rom_en), 64'(1));
    step("rd");
    rd_addr[1*ADDR_W +: ADDR_W] = 11'd6;
    #1; chk("rd.addr6", 64'(bus.rom_addr), 64'(6));
    step("rd");
    rd_addr[1*ADDR_W +: ADDR_W] = 11'd7;
    req[1] = 1'b0;
    #1; chk("rd.addr7", 64'(bus.rom_addr), 64'(7));
    chk("rd.valid_a", 64'(bus.rd_valid), 64'(3'b010));
    step("rd");
    rd_en = '0;
    chk("rd.valid_b", 64'(bus.rd_valid), 64'(3'b010));
    chk("rd.drain_grant", 64'(bus.grant), 64'(0));
    step("rd");
    chk("rd.valid_c", 64'(bus.rd_valid), 64'(3'b010));
    chk("rd.drain_busy", 64'(bus.busy), 64'(1));
    step("rd");
    chk("rd.valid_end", 64'(bus.rd_valid), 64'(0));
    step("rd");

    // Non-owner strobes are ignored
    req = 3'b100;
    step("iso");
    chk("iso.grant", 64'(bus.grant), 64'(3'b100));
    rd_en = 3'b001;
    rd_addr[0 +: ADDR_W]        = 11'h7FF;
    rd_addr[2*ADDR_W +: ADDR_W] = 11'h123;
    opr1[0 +: DW]               = '1;
    opr1[2*DW +: DW]            = 32'hA5C3_1E77;
    opr2[2*DW +: DW]            = 32'h0BAD_F00D;
    #1;
    chk("iso.rom_en", 64'(bus.rom_en), 64'(0));
    chk("iso.rom_addr", 64'(bus.rom_addr), 64'(11'h123));
    chk("iso.opr1", 64'(bus.ma_opr1), 64'(32'hA5C3_1E77));
    chk("iso.opr2", 64'(bus.ma_opr2), 64'(32'h0BAD_F00D));
    step("iso");
    rd_en = 3'b101;
    #1; chk("iso.rom_en_own", 64'(bus.rom_en), 64'(1));
    step("iso");
    rd_en = '0;
    req = '0;
    repeat (ROM_LAT + 3) step("iso");

    // Watchdog: requesters 0 and 1 hold req for 40 cycles
    g0_cycles = 0; after0 = '0; terr_cap = '0; cap_done = 1'b0;
    req = 3'b011;
    for (int i = 0; i < 40; i++) begin
      step("wd");
      if (bus.grant[0]) begin
        g0_cycles++;
      end else if (g0_cycles > 0) begin
        if (!cap_done) begin
          terr_cap = bus.timeout_err;
          cap_done = 1'b1;
        end
        if (after0 == '0 && bus.grant != '0) after0 = bus.grant;
      end
    end
    chk("wd.tenure", 64'(g0_cycles), 64'(TIMEOUT));
    chk("wd.terr_at_drop", 64'(terr_cap), 64'(3'b001));
    chk("wd.next_grant", 64'(after0), 64'(3'b010));
    chk("wd.terr_both", 64'(bus.timeout_err), 64'(3'b011));
    req = 3'b001;
    repeat (6) step("wd");
    chk("wd.fenced", 64'(bus.grant), 64'(0));
    req = 3'b000;
    step("wd");
    req = 3'b001;
    step("wd");
    chk("wd.regrant", 64'(bus.grant), 64'(3'b001));
    req = '0;
    repeat (ROM_LAT + 3) step("wd");

    // Reset one cycle after a read is issued
    req = 3'b010;
    step("mrst");
    rd_en = 3'b010;
    step("mrst");
    rd_en = '0;
    req = '0;
    iRst = 1'b1;
    step("mrst");
    for (int i = 0; i < 4; i++) begin
      chk("mrst.rd_valid", 64'(bus.rd_valid), 64'(0));
      chk("mrst.grant", 64'(bus.grant), 64'(0));
      chk("mrst.terr", 64'(bus.timeout_err), 64'(0));
      chk("mrst.busy", 64'(bus.busy), 64'(0));
      if (i == 1) iRst = 1'b0;
      step("mrst");
    end

    // 100 idle cycles with noisy requester buses
    for (int i = 0; i < 100; i++) begin
      rand_data();
      rd_en = NREQ'($urandom);
      #1;
      chk("idle.grant", 64'(bus.grant), 64'(0));
      chk("idle.rom_en", 64'(bus.rom_en), 64'(0));
      chk("idle.opr1", 64'(bus.ma_opr1), 64'(0));
      chk("idle.opr2", 64'(bus.ma_opr2), 64'(0));
      chk("idle.busy", 64'(bus.busy), 64'(0));
      step("idle");
    end

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rand_data();
      rd_en = NREQ'($urandom);
      for (int r = 0; r < NREQ; r++) begin
        if ($urandom_range(0, 9) == 0) req[r] = ~req[r];
      end
      iRst = ($urandom_range(0, 399) == 0);
      step("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
